// File: rtl/augreal_pkg.sv
// Shared constants for the ZBT bank arbiter: requester ordinals, default widths
// and the default starvation threshold, plus the fixed-priority picker.
package augreal_pkg;

    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned REQ_NTSC = 3;
    localparam int unsigned REQ_VGA  = 2;
    localparam int unsigned REQ_LPF  = 1;
    localparam int unsigned REQ_PTF  = 0;

    localparam int unsigned LOG_ADDR_DEFAULT     = 19;
    localparam int unsigned LOG_MEM_DEFAULT      = 36;
    localparam int unsigned STARVE_LIMIT_DEFAULT = 15;

    typedef enum logic [1:0] {
        ReqPtf  = 2'd0,
        ReqLpf  = 2'd1,
        ReqVga  = 2'd2,
        ReqNtsc = 2'd3
    } req_id_e;

    // One-hot of the highest-priority set bit: NTSC > VGA > LPF > PTF.
    function automatic logic [NUM_REQ-1:0] fixed_pri(input logic [NUM_REQ-1:0] m);
        logic [NUM_REQ-1:0] g;
        g = '0;
        if (m[REQ_NTSC])     g[REQ_NTSC] = 1'b1;
        else if (m[REQ_VGA]) g[REQ_VGA]  = 1'b1;
        else if (m[REQ_LPF]) g[REQ_LPF]  = 1'b1;
        else if (m[REQ_PTF]) g[REQ_PTF]  = 1'b1;
        return g;
    endfunction

endpackage

// File: rtl/zbt_read_tag_pipe.sv
// Shift register of one-hot read tags; the last stage is the read-return strobe.
// Asynchronous clear drops every tag in flight.
module zbt_read_tag_pipe
    import augreal_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] tag_i,
    output logic [NUM_REQ-1:0] tag_o
);

    logic [NUM_REQ-1:0] stage_q [DEPTH];

    // Advance every tag one stage per cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= tag_i;
            for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/zbt_bank_arbiter.sv
// Four-requester arbiter in front of a ZBT SRAM port. Fixed priority
// NTSC > VGA > LPF > PTF, one access per cycle, registered memory drives and
// in-order read return through a tag pipeline.
// Optional starvation promotion is enabled by defining ZBT_STARVE_GUARD_EN.
module zbt_bank_arbiter
    import augreal_pkg::*;
#(
    parameter int unsigned LOG_ADDR     = LOG_ADDR_DEFAULT,
    parameter int unsigned LOG_MEM      = LOG_MEM_DEFAULT,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          wr,
    input  logic [NUM_REQ*LOG_ADDR-1:0] addr,
    input  logic [NUM_REQ*LOG_MEM-1:0]  wdata,
    input  logic                        freeze,
    output logic [NUM_REQ-1:0]          grant,
    output logic [NUM_REQ-1:0]          rvalid,
    output logic [LOG_MEM-1:0]          rdata,
    output logic [LOG_ADDR-1:0]         mem_addr,
    output logic [LOG_MEM-1:0]          mem_write,
    output logic                        mem_wr,
    output logic                        mem_cen,
    input  logic [LOG_MEM-1:0]          mem_read
);

    logic [LOG_ADDR-1:0] sel_addr;
    logic [LOG_MEM-1:0]  sel_wdata;
    logic                sel_wr;
    logic [NUM_REQ-1:0]  rd_tag_q;
    logic [LOG_MEM-1:0]  rdata_q;

`ifdef ZBT_STARVE_GUARD_EN
    logic [3:0]         wait_q [NUM_REQ];
    logic [NUM_REQ-1:0] starved;

    // Flag requesters whose wait count reached the promotion threshold.
    always_comb begin
        starved = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            starved[i] = req[i] && (32'(wait_q[i]) >= STARVE_LIMIT);
        end
    end

    // Starved requesters win over everyone else; fixed order among each group.
    always_comb begin
        if (freeze)           grant = '0;
        else if (|starved)    grant = fixed_pri(starved);
        else                  grant = fixed_pri(req);
    end

    // Saturating wait counters: count while requesting and losing, clear otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) wait_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req[i] && !grant[i]) begin
                    if (wait_q[i] != 4'hf) wait_q[i] <= wait_q[i] + 4'd1;
                end else begin
                    wait_q[i] <= '0;
                end
            end
        end
    end
`else
    // Pure fixed priority; freeze blocks every new grant.
    always_comb begin
        grant = freeze ? '0 : fixed_pri(req);
    end
`endif

    // Mux the granted requester's command; all zero when nothing is granted.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr  = sel_addr  | addr[i*LOG_ADDR +: LOG_ADDR];
                sel_wdata = sel_wdata | wdata[i*LOG_MEM +: LOG_MEM];
                sel_wr    = sel_wr    | wr[i];
            end
        end
    end

    // Register the memory drives and the issue-stage read tag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_cen   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_write <= '0;
            rd_tag_q  <= '0;
        end else begin
            mem_cen   <= |grant;
            mem_wr    <= sel_wr;
            mem_addr  <= sel_addr;
            mem_write <= sel_wdata;
            rd_tag_q  <= grant & ~wr;
        end
    end

    zbt_read_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_tag_pipe (
        .clock (clock),
        .reset (reset),
        .tag_i (rd_tag_q),
        .tag_o (rvalid)
    );

    // Capture returned data so rdata holds between returns.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) rdata_q <= '0;
        else       rdata_q <= rdata;
    end

    assign rdata = (|rvalid) ? mem_read : rdata_q;

endmodule
